// File: rtl/rotary_decoder.sv
// Quadrature front end for vault_controller: synchronises and debounces the encoder phases,
// tracks the Gray sequence and moves a 5-bit dial position one step per full detent.
module rotary_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       n_reset,
   input  logic       quad_a,
   input  logic       quad_b,
   output logic       direction,
   output logic [4:0] vault_code,
   output logic       step,
   output logic       quad_error
);

   localparam logic [7:0]        DebLimit = 8'(DEBOUNCE_CYCLES);
   localparam logic signed [3:0] AccUp    = 4'sd4;
   localparam logic signed [3:0] AccDown  = -4'sd4;

   typedef enum logic [1:0] {
      St00 = 2'b00,
      St01 = 2'b01,
      St10 = 2'b10,
      St11 = 2'b11
   } phase_e;

   // Phase vectors are packed {A, B} so the filtered pair reads directly as a phase state.
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      filt_q, filt_d;
   logic [1:0][7:0] cnt_q, cnt_d;

   phase_e          state_q, state_d, phase_new;
   logic signed [3:0] acc_q, acc_d, acc_step;
   logic [4:0]      code_q, code_d;
   logic            dir_q, dir_d;
   logic            step_q, step_d;
   logic            err_q, err_d;
   logic            up_move, down_move, both_move;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         filt_q  <= 2'b00;
         cnt_q   <= '0;
      end else begin
         sync1_q <= {quad_a, quad_b};
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   // A phase only updates after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (cnt_q[i] + 8'd1 == DebLimit) begin
               filt_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   assign phase_new = phase_e'(filt_q);

   always_comb begin
      up_move   = 1'b0;
      down_move = 1'b0;
      case (state_q)
         St00: begin
            up_move   = (phase_new == St10);
            down_move = (phase_new == St01);
         end
         St10: begin
            up_move   = (phase_new == St11);
            down_move = (phase_new == St00);
         end
         St11: begin
            up_move   = (phase_new == St01);
            down_move = (phase_new == St10);
         end
         St01: begin
            up_move   = (phase_new == St00);
            down_move = (phase_new == St11);
         end
         default: ;
      endcase
      both_move = (phase_new != state_q) && !up_move && !down_move;
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= St00;
         acc_q   <= '0;
         code_q  <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         code_q  <= code_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = phase_new;
      acc_d    = acc_q;
      code_d   = code_q;
      dir_d    = dir_q;
      step_d   = 1'b0;
      err_d    = 1'b0;
      acc_step = acc_q;
      if (up_move) begin
         acc_step = acc_q + 4'sd1;
      end else if (down_move) begin
         acc_step = acc_q - 4'sd1;
      end

      if (both_move) begin
         err_d = 1'b1;
         acc_d = '0;
      end else if ((up_move || down_move) && (phase_new == St00)) begin
         // Arriving at rest: only a full four-step excursion counts as a detent.
         acc_d = '0;
         if (acc_step == AccUp) begin
            code_d = code_q + 5'd1;
            dir_d  = 1'b1;
            step_d = 1'b1;
         end else if (acc_step == AccDown) begin
            code_d = code_q - 5'd1;
            dir_d  = 1'b0;
            step_d = 1'b1;
         end
      end else begin
         acc_d = acc_step;
      end
   end

   assign direction  = dir_q;
   assign vault_code = code_q;
   assign step       = step_q;
   assign quad_error = err_q;

endmodule
